mul_div_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. It owns the HI/LO result registers that the single-cycle ALU cannot produce in one pass. On an accepted `start` it runs an unsigned shift-add multiply or a restoring divide over WIDTH cycles. It raises `busy` so the hazard unit can stall the pipeline, then pulses `done` when HI/LO are valid.

---
 rtl/mul_div_ctrl.sv | 116 +++++++++++
 tb/tb_mul_div_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl.sv
// Multi-cycle unsigned multiply / restoring divide sequencer owning the HI/LO result registers.
// A run takes WIDTH cycles with busy high, then done pulses for one cycle as HI/LO become valid.
module mul_div_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic               op_r;
   logic [WIDTH-1:0]   b_r;
   logic [2*WIDTH-1:0] p_r;
   logic [WIDTH-1:0]   r_r;
   logic [WIDTH-1:0]   q_r;

   logic               accept;
   logic               last;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] p_next;
   logic [WIDTH:0]     r_shift;
   logic               r_ge;
   logic [WIDTH-1:0]   r_next;
   logic [WIDTH-1:0]   q_next;

   assign accept = start && ((state == S_IDLE) || (state == S_DONE));
   assign last   = (count == CW'(WIDTH - 1));
   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);

   // The partial remainder is held in WIDTH bits: after each restore step it is below the
   // divisor, so the extra bit only exists transiently in r_shift for the compare.
   always_comb begin
      mul_sum = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, b_r} : '0);
      p_next  = {mul_sum, p_r[WIDTH-1:1]};
      r_shift = {r_r, q_r[WIDTH-1]};
      r_ge    = (r_shift >= {1'b0, b_r});
      r_next  = r_ge ? (r_shift[WIDTH-1:0] - b_r) : r_shift[WIDTH-1:0];
      q_next  = {q_r[WIDTH-2:0], r_ge};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         count       <= '0;
         op_r        <= 1'b0;
         b_r         <= '0;
         p_r         <= '0;
         r_r         <= '0;
         q_r         <= '0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               count <= count + 1'b1;
               if (op_r) begin
                  r_r <= r_next;
                  q_r <= q_next;
               end else begin
                  p_r <= p_next;
               end
               if (last) begin
                  state <= S_DONE;
                  if (op_r) begin
                     hi <= r_next;
                     lo <= q_next;
                  end else begin
                     hi <= p_next[2*WIDTH-1:WIDTH];
                     lo <= p_next[WIDTH-1:0];
                  end
               end
            end
            default: begin
               if (accept) begin
                  op_r  <= op;
                  b_r   <= opB;
                  p_r   <= {{WIDTH{1'b0}}, opA};
                  r_r   <= '0;
                  q_r   <= opA;
                  count <= '0;
                  if (op && (opB == '0)) begin
                     state       <= S_DONE;
                     hi          <= opA;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= S_RUN;
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed HI/LO and latency expectations.
module tb_mul_div_ctrl;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] opA = '0;
   logic [W-1:0] opB = '0;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0       = 0;

   mul_div_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: results from plain arithmetic, timing from a remaining-cycle counter.
   logic [2*W-1:0] in_prod;
   assign in_prod = {{W{1'b0}}, opA} * {{W{1'b0}}, opB};

   int           m_left = 0;
   bit           m_done = 1'b0;
   bit           m_dbz  = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_hi <= pend_hi;
            m_lo <= pend_lo;
         end
      end else if (start) begin
         if (op && opB == 0) begin
            m_dbz  <= 1'b1;
            m_done <= 1'b1;
            m_hi   <= opA;
            m_lo   <= '1;
         end else begin
            m_dbz  <= 1'b0;
            m_done <= 1'b0;
            m_left <= W;
            if (op) begin
               pend_hi <= opA % opB;
               pend_lo <= opA / opB;
            end else begin
               pend_hi <= in_prod[2*W-1:W];
               pend_lo <= in_prod[W-1:0];
            end
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("busy", busy, m_left > 0);
         chk("done", done, m_done);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("div_by_zero", div_by_zero, m_dbz);
      end
   end

   task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; op = o; opA = a; opB = b;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   // Waits (bounded) for done, then checks which edge after acceptance raised it.
   task automatic wait_done(input string tag, input int exp_edge);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 40);
      if (!done) chk({tag, "_timeout"}, done, 1);
      else       chk({tag, "_edge"}, cyc - t0, exp_edge);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_dbz", div_by_zero, 0);

      issue(1'b0, 16'd3, 16'd5);
      wait_done("mul3x5", 16);
      chk("mul3x5_hi", hi, 16'h0000);
      chk("mul3x5_lo", lo, 16'h000F);
      chk("mul3x5_dbz", div_by_zero, 0);

      repeat (2) @(negedge clk);
      issue(1'b0, 16'hFFFF, 16'hFFFF);
      repeat (5) @(negedge clk);
      chk("hold_busy", busy, 1);
      chk("hold_hi", hi, 16'h0000);
      chk("hold_lo", lo, 16'h000F);
      wait_done("mulmax", 16);
      chk("mulmax_hi", hi, 16'hFFFE);
      chk("mulmax_lo", lo, 16'h0001);

      issue(1'b1, 16'd100, 16'd7);
      wait_done("div100_7", 16);
      chk("div100_7_lo", lo, 16'd14);
      chk("div100_7_hi", hi, 16'd2);

      issue(1'b1, 16'h0005, 16'h0009);
      wait_done("div5_9", 16);
      chk("div5_9_lo", lo, 16'd0);
      chk("div5_9_hi", hi, 16'd5);

      @(negedge clk);
      issue(1'b1, 16'h1234, 16'h0000);
      wait_done("dbz", 0);
      chk("dbz_busy", busy, 0);
      chk("dbz_hi", hi, 16'h1234);
      chk("dbz_lo", lo, 16'hFFFF);
      chk("dbz_flag", div_by_zero, 1);
      issue(1'b0, 16'd6, 16'd7);
      chk("dbz_clear", div_by_zero, 0);
      chk("dbz_next_busy", busy, 1);
      wait_done("mul6x7", 16);
      chk("mul6x7_lo", lo, 16'h002A);
      chk("mul6x7_hi", hi, 16'h0000);

      @(negedge clk);
      issue(1'b0, 16'h1234, 16'h0010);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 1'b1; opA = 16'd9; opB = 16'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore", 16);
      chk("ignore_hi", hi, 16'h0001);
      chk("ignore_lo", lo, 16'h2340);

      @(negedge clk);
      start = 1'b1; op = 1'b1; opA = 16'd1000; opB = 16'd10;
      @(posedge clk); #1;
      t0 = cyc;
      op = 1'b0; opA = 16'h00FF; opB = 16'h0101;
      wait_done("b2b_first", 16);
      chk("b2b_first_lo", lo, 16'd100);
      chk("b2b_first_hi", hi, 16'd0);
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_done_fall", done, 0);
      wait_done("b2b_second", 16);
      chk("b2b_second_hi", hi, 16'h0000);
      chk("b2b_second_lo", lo, 16'hFFFF);

      @(negedge clk);
      issue(1'b0, 16'hABCD, 16'h1234);
      repeat (7) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, 16'd2, 16'd2);
      wait_done("mul2x2", 16);
      chk("mul2x2_lo", lo, 16'd4);
      chk("mul2x2_hi", hi, 16'd0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
